// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues data-memory requests for loads/stores,
// formats load data and forwards writeback copies of the instruction fields.
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 7
`endif
`ifndef LOAD_WORD
`define LOAD_WORD 7'b0000011
`endif
`ifndef STORE_WORD
`define STORE_WORD 7'b0100011
`endif

module memory_access #(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int PC_WIDTH    = 32,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic                     me_clk,
  input  logic                     me_rst,
  input  logic                     me_i_ce,
  input  logic [`OPCODE_WIDTH-1:0] me_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]   me_i_funct,
  input  logic [DWIDTH-1:0]        me_i_alu_result,
  input  logic [DWIDTH-1:0]        me_i_rs2_data,
  input  logic [AWIDTH-1:0]        me_i_rd_addr,
  input  logic                     me_i_we_rd,
  input  logic [PC_WIDTH-1:0]      me_i_pc,
  input  logic                     me_i_stall,
  input  logic                     me_i_flush,
  output logic                     me_o_req,
  output logic                     me_o_wr,
  output logic [DWIDTH-1:0]        me_o_addr,
  output logic [DWIDTH-1:0]        me_o_wdata,
  output logic [3:0]               me_o_byte_en,
  input  logic                     me_i_ack,
  input  logic [DWIDTH-1:0]        me_i_rdata,
  output logic                     me_o_ce,
  output logic [`OPCODE_WIDTH-1:0] me_o_opcode,
  output logic [FUNCT_WIDTH-1:0]   me_o_funct,
  output logic [AWIDTH-1:0]        me_o_rd_addr,
  output logic                     me_o_we_rd,
  output logic [DWIDTH-1:0]        me_o_rd_data,
  output logic [PC_WIDTH-1:0]      me_o_pc,
  output logic [DWIDTH-1:0]        me_o_data_load,
  output logic                     me_o_we,
  output logic                     me_o_stall,
  output logic                     me_o_flush
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]               state_reg;
  logic                     killed_reg;
  logic                     acked_reg;
  logic                     is_load_reg;
  logic [`OPCODE_WIDTH-1:0] opcode_reg;
  logic [FUNCT_WIDTH-1:0]   funct_reg;
  logic [AWIDTH-1:0]        rd_addr_reg;
  logic                     we_rd_reg;
  logic [PC_WIDTH-1:0]      pc_reg;
  logic [DWIDTH-1:0]        alu_reg;
  logic [DWIDTH-1:0]        data_hold_reg;

  logic              is_store_op;
  logic              is_mem_op;
  logic              accept;
  logic              in_wait;
  logic              ack_now;
  logic              kill_now;
  logic              finish;
  logic              complete;
  logic [3:0]        store_be;
  logic [DWIDTH-1:0] store_wdata;
  logic [7:0]        lane [4];
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [DWIDTH-1:0] load_fmt;
  logic [DWIDTH-1:0] result_data;

  always_comb begin
    is_store_op = (me_i_opcode == `STORE_WORD);
    is_mem_op   = is_store_op || (me_i_opcode == `LOAD_WORD);
    accept      = (state_reg == ST_IDLE) && me_i_ce && !me_i_stall && !me_i_flush;
    in_wait     = (state_reg == ST_WAIT);
    ack_now     = in_wait && me_i_ack && !acked_reg;
    kill_now    = killed_reg || me_i_flush;
    // A transaction retires once memory has answered, unless a stall holds a live result back.
    finish      = in_wait && (ack_now || acked_reg) && (kill_now || !me_i_stall);
    complete    = finish && !kill_now;
  end

  always_comb begin
    store_be    = 4'b0000;
    store_wdata = '0;
    if (is_store_op) begin
      case (me_i_funct[1:0])
        2'b00: begin
          store_be    = 4'b0001 << me_i_alu_result[1:0];
          store_wdata = {4{me_i_rs2_data[7:0]}};
        end
        2'b01: begin
          store_be    = me_i_alu_result[1] ? 4'b1100 : 4'b0011;
          store_wdata = {2{me_i_rs2_data[15:0]}};
        end
        default: begin
          store_be    = 4'b1111;
          store_wdata = me_i_rs2_data;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = me_i_rdata[8*gi +: 8];
    end
  endgenerate

  // Lane selection uses the address latched at accept, not the live ALU input.
  assign sel_byte = lane[alu_reg[1:0]];
  assign sel_half = alu_reg[1] ? me_i_rdata[31:16] : me_i_rdata[15:0];

  always_comb begin
    case (funct_reg)
      3'b000:  load_fmt = {{(DWIDTH-8){sel_byte[7]}}, sel_byte};
      3'b100:  load_fmt = {{(DWIDTH-8){1'b0}}, sel_byte};
      3'b001:  load_fmt = {{(DWIDTH-16){sel_half[15]}}, sel_half};
      3'b101:  load_fmt = {{(DWIDTH-16){1'b0}}, sel_half};
      default: load_fmt = me_i_rdata;
    endcase
  end

  assign result_data = acked_reg ? data_hold_reg : load_fmt;

  always_ff @(posedge me_clk or negedge me_rst) begin
    if (!me_rst) begin
      state_reg     <= ST_IDLE;
      killed_reg    <= 1'b0;
      acked_reg     <= 1'b0;
      is_load_reg   <= 1'b0;
      opcode_reg    <= '0;
      funct_reg     <= '0;
      rd_addr_reg   <= '0;
      we_rd_reg     <= 1'b0;
      pc_reg        <= '0;
      alu_reg       <= '0;
      data_hold_reg <= '0;
      me_o_req      <= 1'b0;
      me_o_wr       <= 1'b0;
      me_o_addr     <= '0;
      me_o_wdata    <= '0;
      me_o_byte_en  <= 4'b0000;
      me_o_stall    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept && is_mem_op) begin
            state_reg    <= ST_WAIT;
            killed_reg   <= 1'b0;
            acked_reg    <= 1'b0;
            is_load_reg  <= !is_store_op;
            opcode_reg   <= me_i_opcode;
            funct_reg    <= me_i_funct;
            rd_addr_reg  <= me_i_rd_addr;
            we_rd_reg    <= me_i_we_rd;
            pc_reg       <= me_i_pc;
            alu_reg      <= me_i_alu_result;
            me_o_req     <= 1'b1;
            me_o_wr      <= is_store_op;
            me_o_addr    <= {me_i_alu_result[DWIDTH-1:2], 2'b00};
            me_o_wdata   <= store_wdata;
            me_o_byte_en <= store_be;
            me_o_stall   <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (ack_now) begin
            me_o_req <= 1'b0;
          end
          if (finish) begin
            state_reg  <= ST_IDLE;
            me_o_stall <= 1'b0;
            acked_reg  <= 1'b0;
            killed_reg <= 1'b0;
          end else begin
            // Result arrived under stall: park it until the stall lifts.
            if (ack_now) begin
              acked_reg     <= 1'b1;
              data_hold_reg <= load_fmt;
            end
            if (me_i_flush) begin
              killed_reg <= 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge me_clk or negedge me_rst) begin
    if (!me_rst) begin
      me_o_ce        <= 1'b0;
      me_o_opcode    <= '0;
      me_o_funct     <= '0;
      me_o_rd_addr   <= '0;
      me_o_we_rd     <= 1'b0;
      me_o_rd_data   <= '0;
      me_o_pc        <= '0;
      me_o_data_load <= '0;
      me_o_we        <= 1'b0;
      me_o_flush     <= 1'b0;
    end else begin
      me_o_flush <= me_i_flush;
      if (me_i_flush) begin
        me_o_ce    <= 1'b0;
        me_o_we    <= 1'b0;
        me_o_we_rd <= 1'b0;
      end else if (complete) begin
        me_o_ce      <= 1'b1;
        me_o_we      <= is_load_reg;
        me_o_opcode  <= opcode_reg;
        me_o_funct   <= funct_reg;
        me_o_rd_addr <= rd_addr_reg;
        me_o_we_rd   <= we_rd_reg;
        me_o_pc      <= pc_reg;
        me_o_rd_data <= is_load_reg ? result_data : alu_reg;
        if (is_load_reg) begin
          me_o_data_load <= result_data;
        end
      end else if (me_i_stall) begin
        me_o_ce <= me_o_ce;
      end else if (accept && !is_mem_op) begin
        me_o_ce      <= 1'b1;
        me_o_we      <= 1'b0;
        me_o_opcode  <= me_i_opcode;
        me_o_funct   <= me_i_funct;
        me_o_rd_addr <= me_i_rd_addr;
        me_o_we_rd   <= me_i_we_rd;
        me_o_pc      <= me_i_pc;
        me_o_rd_data <= me_i_alu_result;
      end else begin
        me_o_ce <= 1'b0;
        me_o_we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memoryaccess

Interface
REQ-001 SHALL have parameters DWIDTH 32 (data width), AWIDTH 5 (register address width), PC_WIDTH 32 (PC width), FUNCT_WIDTH 3 (funct3 width).
REQ-002 SHALL have ports, in order:
- me_clk  in  1  clock; rising edge.
- me_rst  in  1  reset; asynchronous, active-low.
- me_i_ce  in  1  execute-stage instruction valid.
- me_i_opcode  in  `OPCODE_WIDTH  instruction opcode.
- me_i_funct  in  FUNCT_WIDTH  funct3.
- me_i_alu_result  in  DWIDTH  memory address, or rd data for non-memory ops.
- me_i_rs2_data  in  DWIDTH  store data.
- me_i_rd_addr  in  AWIDTH  destination register.
- me_i_we_rd  in  1  rd write enable.
- me_i_pc  in  PC_WIDTH  instruction PC.
- me_i_stall  in  1  downstream stall.
- me_i_flush  in  1  pipeline flush.
- me_o_req  out  1  data-memory request.
- me_o_wr  out  1  1 = store, 0 = load.
- me_o_addr  out  DWIDTH  word-aligned address, bits [1:0] = 0.
- me_o_wdata  out  DWIDTH  lane-replicated store data.
- me_o_byte_en  out  4  store byte enables.
- me_i_ack  in  1  memory acknowledge.
- me_i_rdata  in  DWIDTH  memory read word, valid with me_i_ack.
- me_o_ce, me_o_opcode, me_o_funct, me_o_rd_addr, me_o_we_rd, me_o_rd_data, me_o_pc  out  —  writeback-stage copies of the corresponding inputs.
- me_o_data_load  out  DWIDTH  formatted load data.
- me_o_we  out  1  load data valid.
- me_o_stall  out  1  upstream stall.
- me_o_flush  out  1  registered me_i_flush.

Function
REQ-003 SHALL use a two-state FSM: IDLE and WAIT.
REQ-004 SHALL accept an instruction in IDLE when me_i_ce=1, me_i_stall=0 and me_i_flush=0.
REQ-005 Accepted non-memory op: next edge loads all me_o_* copies, me_o_ce=1, me_o_we=0, me_o_rd_data=me_i_alu_result; state remains IDLE.
REQ-006 Accepted op with opcode `LOAD_WORD or `STORE_WORD:
- next edge asserts me_o_req and me_o_stall;
- drives me_o_addr={alu[31:2],2'b00};
- sets me_o_wr=1 for a store, 0 for a load;
- latches the instruction fields;
- enters WAIT.
REQ-007 In WAIT, me_o_req, me_o_wr, me_o_addr, me_o_wdata and me_o_byte_en SHALL hold stable until the cycle me_i_ack=1.
REQ-008 On ack in WAIT, the next edge SHALL:
- deassert me_o_req and me_o_stall;
- pulse me_o_ce=1 for one cycle;
- set me_o_we=1 for a load, 0 for a store;
- return to IDLE.
REQ-009 Load formatting SHALL use the byte offset off = alu[1:0] latched at accept:
- funct 000 LB: sign-extend byte off.
- funct 100 LBU: zero-extend byte off.
- funct 001 LH: sign-extend halfword alu[1].
- funct 101 LHU: zero-extend halfword alu[1].
- funct 010 LW: full word.
- other funct: full word.
REQ-010 Store byte enables SHALL be:
- SB: 4'b0001<<off, wdata = byte replicated ×4.
- SH: 4'b0011<<(2*alu[1]), wdata = halfword replicated ×2.
- SW: 4'b1111.
- Loads: byte_en = 0.
REQ-011 Misaligned addresses SHALL raise no exception; alignment is forced per REQ-009/010.
REQ-012 me_o_ce SHALL be 0 in every cycle without a new completion; me_o_we_rd, me_o_rd_addr and me_o_rd_data hold their last values.
REQ-013 me_i_stall=1 SHALL freeze all writeback-side outputs and block acceptance; an outstanding WAIT transaction still completes and its result is held until me_i_stall falls, then me_o_ce pulses.
REQ-014 me_i_flush=1 SHALL:
- force me_o_ce=0, me_o_we=0 and me_o_we_rd=0 on the next edge;
- block acceptance.
In WAIT, flush SHALL mark the transaction killed: the request is held until ack, then it completes with no me_o_ce pulse; an issued store still writes memory.
REQ-015 me_o_flush SHALL equal me_i_flush delayed one cycle.
REQ-016 When ack and flush coincide in WAIT, the transaction SHALL be killed.
REQ-017 An ack arriving in IDLE SHALL be ignored.

Reset
REQ-018 me_rst=0 SHALL immediately force state IDLE and all outputs to 0, including me_o_req mid-WAIT; the aborted transaction is dropped.
REQ-019 The first accept SHALL occur at the first qualifying edge after me_rst rises.

Verification
REQ-020 ALU op: ce=1, alu=0x1234, rd=5, we_rd=1 -> next cycle me_o_ce=1, me_o_rd_data=0x1234, me_o_rd_addr=5, me_o_we=0.
REQ-021 LB: addr 0x103, rdata 0x80FF_FF7F, ack after 3 WAIT cycles -> req held 3 cycles with addr 0x100, me_o_stall=1 throughout, then me_o_data_load=0xFFFF_FF80, me_o_we=1, one-cycle me_o_ce.
REQ-022 SH: addr 0x202, rs2=0xABCD_1234 -> byte_en=4'b1100, wdata=0x1234_1234, wr=1; after ack me_o_ce=1, me_o_we=0.
REQ-023 LHU: addr 0x2, rdata 0x8001_0000 -> me_o_data_load=0x0000_8001.
REQ-024 Flush asserted in WAIT; ack 2 cycles later -> req held until ack; me_o_ce stays 0; me_o_flush follows me_i_flush by one cycle.
REQ-025 me_rst=0 asserted in WAIT -> me_o_req=0 and all outputs 0 immediately; after release, a new LW completes normally.
